jno_sequencer: RTL and testbench
================================

Name: jno_sequencer

Overview:
- Sequential stage directly upstream of the instruction-check OR stage; produces its 2-bit `instruct_from_jno` operand.
- Accepts a stream of 2-bit ops, owns the program counter, and resolves jump-if-no-overflow (JNO).
- On a taken jump it redirects the PC and squashes the pipeline for a fixed number of cycles.
- Non-jump ops are forwarded with a single-cycle registered valid.

Parameters:
- PC_W, 8, program counter width; the PC wraps modulo 2^PC_W.
- FLUSH_CYCLES, 2, cycles `instr_ready` is held low after a taken JNO (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; leaves IDLE.
- instr_valid  in  1  upstream op valid.
- instr_op  in  2  00 NOP, 01 ADD, 10 SUB, 11 JNO.
- instr_target  in  PC_W  jump target; meaningful only for JNO.
- overflow  in  1  registered ALU overflow flag, sampled when a JNO is accepted.
- instr_ready  out  1  block can accept an op this cycle.
- pc  out  PC_W  current program counter.
- instruct_from_jno  out  2  op forwarded to the check stage.
- out_valid  out  1  `instruct_from_jno` is valid this cycle.
- jump_taken  out  1  one-cycle pulse on a taken JNO.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async assert, sync release):
  - pc=0, instruct_from_jno=2'b00, out_valid=0, jump_taken=0, halted=0, instr_ready=0.
  - State goes to IDLE; flush counter=0.
- Handshake:
  - An op is accepted when instr_valid && instr_ready on a rising edge.
  - Upstream holds op and target stable until accepted.
- States:
  - IDLE: instr_ready=0. start=1 -> RUN. start is ignored in every other state.
  - RUN: instr_ready=1.
    - Accepted NOP/ADD/SUB: next cycle instruct_from_jno=op, out_valid=1; pc<=pc+1 (wraps at 2^PC_W-1 -> 0).
    - Accepted JNO with overflow=1 (not taken): next cycle instruct_from_jno=2'b00, out_valid=1; pc<=pc+1; stay in RUN.
    - Accepted JNO with overflow=0 and target!=pc (taken): pc<=target; jump_taken=1 for one cycle; out_valid=0; flush counter<=FLUSH_CYCLES; go to FLUSH.
    - Accepted JNO with overflow=0 and target==pc (self-loop): HALT; pc unchanged; jump_taken=0.
  - FLUSH: instr_ready=0, out_valid=0. Counter decrements each cycle; when it reaches 1 -> RUN. Exactly FLUSH_CYCLES cycles with ready low.
  - HALT: instr_ready=0, out_valid=0, halted=1. Exit only by reset.
- Output timing:
  - Latency from accept to output is 1 cycle.
  - out_valid deasserts in any cycle with no accept.
  - instruct_from_jno holds its last value when out_valid=0.
- Edge cases:
  - JNO accepted in the same cycle overflow changes: the sampled value at the clock edge decides.
  - instr_valid high during FLUSH or IDLE: not accepted; no state change.
  - Reset asserted mid-FLUSH or in HALT: immediate return to the reset values above.
  - Target of 2^PC_W-1 is legal.
- PC arithmetic: unsigned, PC_W bits; no carry out.

Optional Feature:
- Macro JNO_TAKEN_CNT_EN.
- Defined:
  - Adds output port taken_count (out, 16), reset 0.
  - Increments on each jump_taken pulse; saturates at 16'hFFFF.
  - Self-loop HALT does not count.
- Undefined: no port, no counter logic; all other behaviour identical.

Decomposition:
- Package jno_pkg:
  - op encodings OP_NOP/OP_ADD/OP_SUB/OP_JNO (2-bit).
  - State encodings ST_IDLE/ST_RUN/ST_FLUSH/ST_HALT (2-bit).
  - Flush counter width constant (4).
- One sub-module: jno_pc_reg.
  - Inputs: clk, rst_n, inc, load, load_val.
  - Owns pc, increment/wrap, and load.
  - load has priority over inc.
- FSM and output registers stay in jno_sequencer.

Test Plan:
- Reset then start; accept ADD, SUB, NOP back-to-back -> instruct_from_jno 01,10,00 on consecutive cycles with out_valid=1; pc 0->3.
- pc=5, JNO target=20, overflow=1 -> out 00 valid, pc=6, no jump_taken, ready stays 1.
- pc=5, JNO target=20, overflow=0, FLUSH_CYCLES=2 -> jump_taken pulse, pc=20, instr_ready low exactly 2 cycles, no out_valid; next ADD yields pc=21.
- pc=255 (PC_W=8), accept ADD -> pc=0; then JNO target=0, overflow=0 -> halted=1, ready=0; instr_valid ignored until rst_n low.
- Assert rst_n low during FLUSH -> all outputs at reset values within the same cycle; start required to resume.
- With JNO_TAKEN_CNT_EN: 3 taken JNOs plus 1 self-loop halt -> taken_count=3.

Source files
------------

// File: rtl/jno_pkg.sv
// Shared encodings for the JNO sequencer: op codes, FSM states, flush counter width.
package jno_pkg;

  localparam int FLUSH_W = 4;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_JNO = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  function automatic logic is_jno(input logic [1:0] op);
    return op == OP_JNO;
  endfunction

endpackage

// File: rtl/jno_pc_reg.sv
// Program counter register: load of a jump target, or increment with modulo-2^PC_W wrap.
// Updates on the edge where load/inc are sampled; load wins when both are high.
module jno_pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/jno_sequencer.sv
// Op sequencer with JNO resolution; accepted ops appear one cycle later, a taken jump squashes
// intake for FLUSH_CYCLES cycles. Optional taken-jump counter under `JNO_TAKEN_CNT_EN.
module jno_sequencer
  import jno_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            instr_valid,
  input  logic [1:0]      instr_op,
  input  logic [PC_W-1:0] instr_target,
  input  logic            overflow,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      instruct_from_jno,
  output logic            out_valid,
  output logic            jump_taken,
  output logic            halted
`ifdef JNO_TAKEN_CNT_EN
  ,
  output logic [15:0]     taken_count
`endif
);

  state_t             state;
  logic [FLUSH_W-1:0] flush_cnt;

  logic accept;
  logic jno_op;
  logic jno_resolve;
  logic jno_taken;
  logic jno_self;
  logic pc_inc;

  // A JNO with overflow set degrades to a NOP; only overflow=0 redirects or halts.
  assign accept      = instr_valid && instr_ready;
  assign jno_op      = is_jno(instr_op);
  assign jno_resolve = accept && jno_op && !overflow;
  assign jno_taken   = jno_resolve && (instr_target != pc);
  assign jno_self    = jno_resolve && (instr_target == pc);
  assign pc_inc      = accept && !(jno_op && !overflow);

  jno_pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (jno_taken),
    .load_val (instr_target),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      flush_cnt         <= '0;
      instr_ready       <= 1'b0;
      instruct_from_jno <= OP_NOP;
      out_valid         <= 1'b0;
      jump_taken        <= 1'b0;
      halted            <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      jump_taken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            instr_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (jno_taken) begin
            state       <= ST_FLUSH;
            flush_cnt   <= FLUSH_W'(FLUSH_CYCLES);
            instr_ready <= 1'b0;
            jump_taken  <= 1'b1;
          end else if (jno_self) begin
            state       <= ST_HALT;
            instr_ready <= 1'b0;
            halted      <= 1'b1;
          end else if (accept) begin
            instruct_from_jno <= jno_op ? OP_NOP : instr_op;
            out_valid         <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Leaving on count==1 gives exactly FLUSH_CYCLES cycles of ready low.
          if (flush_cnt == FLUSH_W'(1)) begin
            state       <= ST_RUN;
            flush_cnt   <= '0;
            instr_ready <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_W'(1);
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JNO_TAKEN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_count <= '0;
    end else if (jno_taken && (taken_count != 16'hFFFF)) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jno_sequencer.sv
// Directed bench for jno_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_jno_sequencer;
  import jno_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       instr_valid;
  logic [1:0] instr_op;
  logic [7:0] instr_target;
  logic       overflow;
  logic       instr_ready;
  logic [7:0] pc;
  logic [1:0] instruct_from_jno;
  logic       out_valid;
  logic       jump_taken;
  logic       halted;
`ifdef JNO_TAKEN_CNT_EN
  logic [15:0] taken_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jno_sequencer #(
    .PC_W        (8),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .instr_valid      (instr_valid),
    .instr_op         (instr_op),
    .instr_target     (instr_target),
    .overflow         (overflow),
    .instr_ready      (instr_ready),
    .pc               (pc),
    .instruct_from_jno(instruct_from_jno),
    .out_valid        (out_valid),
    .jump_taken       (jump_taken),
    .halted           (halted)
`ifdef JNO_TAKEN_CNT_EN
    ,
    .taken_count      (taken_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic vld,
                           input logic [1:0] ins, input logic [7:0] pcv,
                           input logic jt, input logic hlt);
    chk({tag, ".ready"},  32'(instr_ready),       32'(rdy));
    chk({tag, ".valid"},  32'(out_valid),         32'(vld));
    chk({tag, ".instr"},  32'(instruct_from_jno), 32'(ins));
    chk({tag, ".pc"},     32'(pc),                32'(pcv));
    chk({tag, ".jump"},   32'(jump_taken),        32'(jt));
    chk({tag, ".halted"}, 32'(halted),            32'(hlt));
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] tgt, input logic ov);
    instr_valid  = v;
    instr_op     = op;
    instr_target = tgt;
    overflow     = ov;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(1'b0, OP_NOP, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 2'b00, 8'd0, 0, 0);
    rst_n = 1'b1;

    // Valid op while IDLE must be ignored.
    drive(1'b1, OP_ADD, 8'd0, 1'b0);
    @(negedge clk); check_all("idle_ignore", 0, 0, 2'b00, 8'd0, 0, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; check_all("run_entry", 1, 0, 2'b00, 8'd0, 0, 0);

    @(negedge clk); check_all("add", 1, 1, 2'b01, 8'd1, 0, 0); drive(1'b1, OP_SUB, 8'd0, 1'b0);
    @(negedge clk); check_all("sub", 1, 1, 2'b10, 8'd2, 0, 0); drive(1'b1, OP_NOP, 8'd0, 1'b0);
    @(negedge clk); check_all("nop", 1, 1, 2'b00, 8'd3, 0, 0); drive(1'b1, OP_ADD, 8'd0, 1'b0);
    @(negedge clk); check_all("add2", 1, 1, 2'b01, 8'd4, 0, 0);
    @(negedge clk); check_all("add3", 1, 1, 2'b01, 8'd5, 0, 0); drive(1'b1, OP_JNO, 8'd20, 1'b1);

    @(negedge clk); check_all("jno_not_taken", 1, 1, 2'b00, 8'd6, 0, 0);
    drive(1'b1, OP_JNO, 8'd20, 1'b0);
    @(negedge clk); check_all("jno_taken", 0, 0, 2'b00, 8'd20, 1, 0);
    drive(1'b1, OP_ADD, 8'd0, 1'b0);
    @(negedge clk); check_all("flush_1", 0, 0, 2'b00, 8'd20, 0, 0);
    @(negedge clk); check_all("flush_done", 1, 0, 2'b00, 8'd20, 0, 0);
    @(negedge clk); check_all("after_jump", 1, 1, 2'b01, 8'd21, 0, 0);

    drive(1'b1, OP_JNO, 8'd255, 1'b0);
    @(negedge clk); check_all("jump_255", 0, 0, 2'b01, 8'd255, 1, 0);
    drive(1'b1, OP_ADD, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk); check_all("flush_255", 1, 0, 2'b01, 8'd255, 0, 0);
    @(negedge clk); check_all("wrap", 1, 1, 2'b01, 8'd0, 0, 0);

    drive(1'b1, OP_JNO, 8'd7, 1'b0);
    @(negedge clk); check_all("jump_7", 0, 0, 2'b01, 8'd7, 1, 0);
    @(negedge clk);
    @(negedge clk); check_all("flush_7", 1, 0, 2'b01, 8'd7, 0, 0);
    @(negedge clk); check_all("self_halt", 0, 0, 2'b01, 8'd7, 0, 1);

    drive(1'b1, OP_ADD, 8'd0, 1'b0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check_all("halt_hold", 0, 0, 2'b01, 8'd7, 0, 1);
`ifdef JNO_TAKEN_CNT_EN
    chk("taken_count", 32'(taken_count), 32'd3);
`endif

    // Reset from HALT, restart, then reset again in the middle of a flush.
    rst_n = 1'b0;
    #1;
    check_all("reset_halt", 0, 0, 2'b00, 8'd0, 0, 0);
    @(negedge clk); rst_n = 1'b1; drive(1'b0, OP_NOP, 8'd0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; check_all("run2", 1, 0, 2'b00, 8'd0, 0, 0);
    drive(1'b1, OP_JNO, 8'd9, 1'b0);
    @(negedge clk); check_all("jump_9", 0, 0, 2'b00, 8'd9, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_all("reset_flush", 0, 0, 2'b00, 8'd0, 0, 0);
`ifdef JNO_TAKEN_CNT_EN
    chk("taken_count_rst", 32'(taken_count), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1; drive(1'b1, OP_ADD, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_all("need_start", 0, 0, 2'b00, 8'd0, 0, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; check_all("restart", 1, 0, 2'b00, 8'd0, 0, 0);
    @(negedge clk); check_all("post_reset_add", 1, 1, 2'b01, 8'd1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
